// File: rtl/im_loader.sv
// im_loader: length-prefixed, XOR-checksummed byte stream loader driving the instruction memory write port.
module im_loader #(
  parameter int DIM     = 1024,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 65535
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic [31:0]       DATA,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);
  localparam logic [2:0] S_IDLE = 3'd0, S_LEN_HI = 3'd1, S_LEN_LO = 3'd2, S_DATA = 3'd3,
                         S_WRITE = 3'd4, S_CHECK = 3'd5, S_DONE = 3'd6, S_ERR = 3'd7;
  localparam logic [16:0] dim_l  = 17'(DIM);
  localparam logic [15:0] to_max = 16'(TIMEOUT - 1);
  localparam bit          to_en  = TIMEOUT != 0;
  logic [2:0]  state;
  logic [7:0]  len_hi, csum;
  logic [15:0] n, to_cnt, new_n;
  logic [1:0]  byte_cnt;
  logic        xfer, timed_out, last, bad_len;
  assign rx_ready  = state == S_LEN_HI || state == S_LEN_LO || state == S_DATA || state == S_CHECK;
  assign busy      = rx_ready || state == S_WRITE;
  assign WE        = state == S_WRITE;
  assign xfer      = rx_ready && rx_valid;
  assign timed_out = to_en && to_cnt == to_max;
  assign new_n     = {len_hi, rx_data};
  assign bad_len   = new_n == 16'd0 || {1'b0, new_n} > dim_l;
  assign last      = 16'(words_written) + 16'd1 == n;
  // State and all status outputs share one register set, so a reset kills any pending write instantly.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= S_IDLE;
      len_hi        <= '0;
      csum          <= '0;
      n             <= '0;
      to_cnt        <= '0;
      byte_cnt      <= '0;
      ADDRESS       <= '0;
      DATA          <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: if (start) begin
          state         <= S_LEN_HI;
          done          <= 1'b0;
          error         <= 1'b0;
          ADDRESS       <= '0;
          words_written <= '0;
          csum          <= '0;
          to_cnt        <= '0;
        end
        S_WRITE: begin
          ADDRESS       <= ADDRESS + 1'b1;
          words_written <= words_written + 1'b1;
          to_cnt        <= '0;
          state         <= last ? S_CHECK : S_DATA;
        end
        default: if (xfer) begin
          to_cnt <= '0;
          case (state)
            S_LEN_HI: begin
              len_hi <= rx_data;
              state  <= S_LEN_LO;
            end
            S_LEN_LO: begin
              n        <= new_n;
              byte_cnt <= '0;
              error    <= bad_len;
              state    <= bad_len ? S_ERR : S_DATA;
            end
            S_DATA: begin
              DATA     <= {DATA[23:0], rx_data};
              csum     <= csum ^ rx_data;
              byte_cnt <= byte_cnt + 1'b1;
              state    <= byte_cnt == 2'd3 ? S_WRITE : S_DATA;
            end
            default: begin
              done  <= rx_data == csum;
              error <= rx_data != csum;
              state <= rx_data == csum ? S_DONE : S_ERR;
            end
          endcase
        end else if (timed_out) begin
          error <= 1'b1;
          state <= S_ERR;
        end else
          to_cnt <= to_cnt + 1'b1;
      endcase
    end
  end
endmodule
